// File: rtl/channel_pkg.sv
// Shared definitions for the parametrised channel transmitter/receiver pair:
// FSM encodings, parity modes, frame layout and the common parity function.
package channel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } rx_state_e;

    localparam bit PAR_MODE_EVEN = 1'b0;
    localparam bit PAR_MODE_ODD  = 1'b1;

    // Data occupies the low bits of a frame; the parity bit sits at the MSB.
    localparam int FRAME_DATA_LSB = 0;

    // Widest frame the parity helper accepts; narrower frames are zero-extended.
    localparam int PARITY_CALC_W = 64;

    function automatic logic calc_parity(input logic [PARITY_CALC_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/channel_receiver_p_if.sv
// Channel-side and consumer-side signals of the receiver, plus FSM state for observation.
interface channel_receiver_p_if #(
    parameter int DATA_W    = 9,
    parameter int ERR_CNT_W = 8
);
    import channel_pkg::*;

    // Handshake: a word transfers on every clock edge where out_valid and out_ready are both 1;
    // out_valid never depends on out_ready, and out_data is stable while out_valid waits.
    logic                 enable;
    logic [DATA_W:0]      rx_word;
    logic                 out_ready;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_data;
    logic                 parity_err;
    logic                 overflow;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 fifo_full;
    rx_state_e            state;

    modport master (
        output enable, rx_word, out_ready,
        input  out_valid, out_data, parity_err, overflow, err_count, fifo_full, state
    );

    modport slave (
        input  enable, rx_word, out_ready,
        output out_valid, out_data, parity_err, overflow, err_count, fifo_full, state
    );

endinterface

// File: rtl/channel_fifo.sv
// Synchronous first-word-fall-through FIFO; accepts a push while full when a pop happens the same cycle.
module channel_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so wrap-around is free for power-of-two depths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/channel_receiver_p.sv
// Channel receiver: accepts a word once it has been stable for STABLE_CYCLES samples,
// parity-checks it and buffers good words in a FWFT FIFO.
module channel_receiver_p
    import channel_pkg::*;
#(
    parameter int DATA_W        = 9,
    parameter bit PARITY_ODD    = 1'b0,
    parameter int STABLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    channel_receiver_p_if.slave  bus
);
    localparam int FRAME_W = DATA_W + 1;
    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
    localparam bit PAR_MODE = PARITY_ODD ? PAR_MODE_ODD : PAR_MODE_EVEN;

    rx_state_e                state;
    logic [FRAME_W-1:0]       samp;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_next;
    logic [PARITY_CALC_W-1:0] samp_ext;
    logic                     same;
    logic                     accept;
    logic                     good;
    logic                     pop;
    logic                     push;
    logic                     drop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     parity_err_q;
    logic                     overflow_q;
    logic [ERR_CNT_W-1:0]     err_count_q;

    always_comb begin
        samp_ext = '0;
        samp_ext[FRAME_W-1:0] = samp;
        same   = (bus.rx_word == samp);
        good   = (calc_parity(samp_ext) == PAR_MODE);
        // The word in samp has been held long enough; what arrives on this edge does not matter.
        accept = bus.enable && (state == ST_SETTLE) && (cnt == CNT_MAX);
        pop    = ~fifo_empty & bus.out_ready;
        push   = accept & good & (~fifo_full | pop);
        drop   = accept & good & fifo_full & ~pop;
        if (!same) begin
            cnt_next = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= ST_IDLE;
            samp         <= '0;
            cnt          <= '0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            samp         <= bus.rx_word;
            parity_err_q <= accept & ~good;
            overflow_q   <= drop;
            if (accept && !good && err_count_q != ERR_MAX) begin
                err_count_q <= err_count_q + 1'b1;
            end
            if (!bus.enable) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt_next;
                case (state)
                    ST_IDLE:   state <= ST_SETTLE;
                    // A word changing on the accept edge starts its own settle immediately.
                    ST_SETTLE: if (accept) state <= same ? ST_HOLD : ST_SETTLE;
                    ST_HOLD:   if (!same) state <= ST_SETTLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    channel_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (clr_n),
        .push  (push),
        .din   (samp[FRAME_DATA_LSB +: DATA_W]),
        .pop   (pop),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid  = ~fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.parity_err = parity_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.err_count  = err_count_q;
    assign bus.state      = state;

endmodule

// File: doc/channel_receiver_p.md
Name: channel_receiver_p

Overview:
Parametrised successor to the fixed 9-bit channel receiver. It samples a parallel transmitted word (data plus parity bit) and accepts a word only after it has been stable for a programmable number of cycles. This rejects the corrupted words seen when the clock runs too fast for the channel. Each accepted word is parity-checked, good words are buffered in a small FIFO with a valid/ready output handshake, and parity errors and overflows are counted or flagged. The block sits between the channel wires and the downstream consumer.

Parameters:
DATA_W, 9, payload width; input word is DATA_W+1 bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
STABLE_CYCLES, 2, consecutive identical samples required before acceptance (>=1).
FIFO_DEPTH, 4, buffered good words (power of two, >=2).
ERR_CNT_W, 8, parity-error counter width.

Ports:
clk  in  1  system clock, rising edge.
clr_n  in  1  asynchronous active-low reset.
enable  in  1  1 = receive; 0 = hold in IDLE, no acceptance.
rx_word  in  DATA_W+1  channel word; [DATA_W] = parity bit, [DATA_W-1:0] = data.
out_ready  in  1  consumer ready.
out_valid  out  1  FIFO non-empty.
out_data  out  DATA_W  FIFO head (first-word-fall-through).
parity_err  out  1  one-cycle pulse on an accepted word failing parity.
overflow  out  1  one-cycle pulse when a good word is dropped because the FIFO is full.
err_count  out  ERR_CNT_W  saturating count of parity errors.
fifo_full  out  1  FIFO holds FIFO_DEPTH words.

Behaviour:
- Reset (clr_n=0, async): the following clear immediately:
  - out_valid=0, out_data=0, parity_err=0, overflow=0, err_count=0, fifo_full=0.
  - Sample register=0, stable count=0, FIFO empty, state=IDLE.
  - Reset mid-operation discards FIFO contents and any partial settle.
- Input register samples rx_word every edge. Stable count (width clog2(STABLE_CYCLES+1)) works as follows:
  - Resets to 1 when the new sample differs from the previous one.
  - Increments when the sample is equal, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: enable=0; count held at 0. Goes to SETTLE on enable=1.
  - SETTLE: counting. When count reaches STABLE_CYCLES, the word is accepted for exactly one cycle and the FSM goes to HOLD.
  - HOLD: word already taken; waits for a sample change, then goes to SETTLE with count=1. A constant word is never accepted twice.
  - enable=0 in any state goes to IDLE. The FIFO keeps draining.
- Latency: let edge k be the first edge capturing a new value.
  - The value must be held through edge k+STABLE_CYCLES-1; it is accepted at edge k+STABLE_CYCLES.
  - If the FIFO was empty, out_valid=1 and out_data=the data immediately after that edge.
  - A change before acceptance restarts the count; nothing is accepted.
- Parity check: ^rx_word must equal PARITY_ODD.
  - Fail: parity_err pulses for 1 cycle and err_count increments, saturating at 2^ERR_CNT_W-1. The word is not pushed.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push of a good word when not full. If full with no pop that cycle, the word is dropped and overflow pulses.
  - Simultaneous push and pop when full: both happen; fifo_full stays 1, no overflow.
  - Simultaneous push and pop when empty: the pushed word is visible on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- parity_err and overflow are never both 1 in the same cycle.

Decomposition:
- Shared package channel_pkg holds:
  - FSM state encodings IDLE/SETTLE/HOLD.
  - Parity-mode constants.
  - The frame-layout constant (parity bit at MSB).
  - A parity-compute function shared with the parametrised transmitter.
- One sub-module: channel_fifo (synchronous FWFT FIFO, parameters WIDTH and DEPTH, async active-low reset), with full/empty outputs.

Test Plan:
- Reset/idle: clr_n=0 then 1, enable=0, rx_word=10'h0A5 held 10 cycles -> out_valid=0, err_count=0, no pulses.
- Good word latency (even parity, STABLE_CYCLES=2): enable=1, rx_word=10'h3A5 from edge k -> accepted at edge k+2; out_valid=1, out_data=9'h1A5; held 20 more cycles -> still exactly 1 word.
- Glitch rejection: rx_word alternates 10'h3A5/10'h0A5 every cycle (too-fast clock) for 16 cycles -> no acceptance, out_valid=0; then holds 10'h0A5 -> one word 9'h0A5.
- Parity error: stable rx_word=10'h1A5 -> parity_err pulses once, err_count=1, FIFO unchanged. Force 300 errors with ERR_CNT_W=8 -> err_count=255.
- Overflow/backpressure: out_ready=0, push 5 distinct good words with FIFO_DEPTH=4 -> fifo_full=1, one overflow pulse on word 5. Then out_ready=1 -> words 1-4 drained in order.
- Full push/pop and reset: FIFO full, out_ready=1 while a new good word is accepted -> no overflow, fifo_full stays 1. Then clr_n=0 mid-stream -> out_valid=0 immediately, FIFO empty.
